cla_lookahead_unit: RTL and testbench
=====================================

Name: cla_lookahead_unit

Overview:
- 4-group carry-lookahead generator. Takes per-group generate/propagate pairs and a carry-in.
- Produces the internal carries C1..C4 and the block-level group generate (G) and propagate (P).
- Sits between 4-bit adder slices, or between lower-level lookahead units, in a hierarchical CLA adder/ALU.
- Outputs are registered with one clock cycle of latency, plus a valid pipeline bit.

Parameters:
- none (the width is fixed at 4 groups)

Ports:
- clk       input   1  rising-edge clock
- rst       input   1  synchronous, active-high reset
- in_valid  input   1  inputs are valid this cycle
- g0        input   1  generate, group 0 (least significant)
- p0        input   1  propagate, group 0
- g1        input   1  generate, group 1
- p1        input   1  propagate, group 1
- g2        input   1  generate, group 2
- p2        input   1  propagate, group 2
- g3        input   1  generate, group 3 (most significant)
- p3        input   1  propagate, group 3
- cin       input   1  carry into group 0
- c1        output  1  carry into group 1
- c2        output  1  carry into group 2
- c3        output  1  carry into group 3
- c4        output  1  carry out of group 3
- g_out     output  1  block generate G
- p_out     output  1  block propagate P
- out_valid output  1  registered copy of in_valid

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Carries use flattened two-level sum-of-products. There is no ripple chain through c1..c3.
  - c1 = g0 | p0&cin
  - c2 = g1 | p1&g0 | p1&p0&cin
  - c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&cin
  - c4 = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 | p3&p2&p1&p0&cin
- Block terms: G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0; P = p0&p1&p2&p3.
- G and P are independent of cin.
- Latency and registering:
  - All six results are computed combinationally from the current inputs.
  - They are captured on every rising clk edge where rst=0, regardless of in_valid.
  - out_valid takes in_valid on the same edge.
  - Latency is exactly 1 cycle, with a new result every cycle (fully pipelined, no stall or backpressure).
- Reset: on a rising edge with rst=1, c1..c4, g_out, p_out and out_valid all go to 0.
  - Reset takes priority over the inputs.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid output after rst deasserts appears 1 cycle after the first sampled in_valid=1.
- Outputs hold their value between edges.
- No X-propagation special cases: inputs are treated as plain 0/1.
- Consistency identity, true every cycle: c4 == g_out | (p_out & cin), evaluated on the cin sampled with that result.
- Inputs with both g and p set for the same group are legal and evaluated by the equations unchanged.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0 and out_valid=0; release rst -> outputs follow the inputs one cycle later.
- g3..g0=0110, p3..p0=1111, cin=0, in_valid=1 -> next cycle c1=0, c2=1, c3=1, c4=1, G=1, P=1, out_valid=1.
- g3..g0=0100, p3..p0=0111, cin=0 -> next cycle c1=0, c2=0, c3=1, c4=0, G=0, P=0.
- g3..g0=0001, p3..p0=1110, cin=0 -> next cycle c1=1, c2=1, c3=1, c4=1, G=1, P=0.
- Full propagate: g=0000, p=1111, with cin=1 then cin=0 on back-to-back cycles:
  - first result: c1..c4=1111, G=0, P=1
  - second result: c1..c4=0000, G=0, P=1
  - confirms 1-cycle latency and no stall between results.
- Exhaustive: all 512 combinations of {g,p,cin} streamed one per cycle, with rst pulsed once mid-stream.
  - Each output must match the equations 1 cycle after its inputs.
  - The cycle after the rst edge reads all-zero.
  - The c4 == G | P&cin identity is checked every cycle.

Source files
------------

// File: rtl/cla_lookahead_unit.sv
// Four-group carry-lookahead generator: flattened two-level carries C1..C4 plus
// block generate/propagate, all registered with one cycle of latency.
module cla_lookahead_unit (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic g0,
  input  logic p0,
  input  logic g1,
  input  logic p1,
  input  logic g2,
  input  logic p2,
  input  logic g3,
  input  logic p3,
  input  logic cin,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic g_out,
  output logic p_out,
  output logic out_valid
);

  logic c1_d, c2_d, c3_d, c4_d, g_d, p_d;
  logic c1_q, c2_q, c3_q, c4_q, g_q, p_q, valid_q;

  // Each carry is a direct sum-of-products of the group terms; no carry feeds another.
  always_comb begin
    c1_d = g0 | (p0 & cin);
    c2_d = g1 | (p1 & g0) | (p1 & p0 & cin);
    c3_d = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & cin);
    c4_d = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
         | (p3 & p2 & p1 & p0 & cin);
    g_d  = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
    p_d  = p3 & p2 & p1 & p0;
  end

  // Results are captured every cycle; in_valid only travels alongside as a tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      c3_q    <= 1'b0;
      c4_q    <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      c4_q    <= c4_d;
      g_q     <= g_d;
      p_q     <= p_d;
      valid_q <= in_valid;
    end
  end

  assign c1        = c1_q;
  assign c2        = c2_q;
  assign c3        = c3_q;
  assign c4        = c4_q;
  assign g_out     = g_q;
  assign p_out     = p_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cla_lookahead_unit.sv
// Self-checking bench for cla_lookahead_unit: directed cases, exhaustive sweep
// with a mid-stream reset, and random traffic against a behavioural carry model.
module tb_cla_lookahead_unit;

  logic clk = 1'b0;
  logic rst, in_valid, cin;
  logic g0, p0, g1, p1, g2, p2, g3, p3;
  logic c1, c2, c3, c4, g_out, p_out, out_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [6:0]  exp_q;
  logic        have_prev = 1'b0;

  always #5 clk = ~clk;

  cla_lookahead_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .g0(g0), .p0(p0), .g1(g1), .p1(p1), .g2(g2), .p2(p2), .g3(g3), .p3(p3),
    .cin(cin),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .g_out(g_out), .p_out(p_out), .out_valid(out_valid)
  );

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%b expected=%b", tag, got, want);
    end
  endtask

  function automatic logic [6:0] observed();
    return {out_valid, p_out, g_out, c4, c3, c2, c1};
  endfunction

  // Carry into the next group is produced if the group generates, or propagates
  // an incoming carry; G is the carry out with no carry in, P needs all propagates.
  function automatic logic [6:0] ref_model(input logic [3:0] g, input logic [3:0] p,
                                           input logic ci, input logic v, input logic r);
    logic [3:0] c;
    logic       carry, gblk;
    if (r) return '0;
    carry = ci;
    for (int i = 0; i < 4; i++) begin
      carry = g[i] | (p[i] & carry);
      c[i]  = carry;
    end
    gblk = 1'b0;
    for (int i = 0; i < 4; i++) gblk = g[i] | (p[i] & gblk);
    return {v, &p, gblk, c};
  endfunction

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] p,
                      input logic ci, input logic v, input logic r);
    logic [6:0] o;
    @(negedge clk);
    {g3, g2, g1, g0} = g;
    {p3, p2, p1, p0} = p;
    cin = ci; in_valid = v; rst = r;
    #1;
    if (have_prev) check_eq("hold", observed(), exp_q);
    @(posedge clk);
    #1;
    exp_q = ref_model(g, p, ci, v, r);
    have_prev = 1'b1;
    o = observed();
    check_eq(tag, o, exp_q);
    // c4 must always equal G | P&cin for the cin that produced it
    check_eq("ident", {6'b0, o[3]}, {6'b0, o[4] | (o[5] & ci)});
  endtask

  initial begin
    logic [8:0] idx;
    {g3, g2, g1, g0, p3, p2, p1, p0} = '0;
    cin = 1'b0; in_valid = 1'b0; rst = 1'b1;

    step("rst0", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1);
    step("rst1", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1);
    check_eq("rst_const", observed(), 7'b0000000);

    step("dir1", 4'b0110, 4'b1111, 1'b0, 1'b1, 1'b0);
    check_eq("dir1_const", observed(), 7'b1111110);
    step("dir2", 4'b0100, 4'b0111, 1'b0, 1'b1, 1'b0);
    check_eq("dir2_const", observed(), 7'b1000100);
    step("dir3", 4'b0001, 4'b1110, 1'b0, 1'b1, 1'b0);
    check_eq("dir3_const", observed(), 7'b1011111);
    step("prop1", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    check_eq("prop1_const", observed(), 7'b1101111);
    step("prop0", 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    check_eq("prop0_const", observed(), 7'b1100000);
    step("novalid", 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
    check_eq("novalid_const", observed(), 7'b0011111);

    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      if (i == 256) begin
        step("exh_rst", 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1);
        check_eq("exh_rst_const", observed(), 7'b0000000);
      end
      step("exh", idx[3:0], idx[7:4], idx[8], 1'b1, 1'b0);
    end

    for (int i = 0; i < 300; i++)
      step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 31) == 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
